// File: rtl/segment_frame_latch.sv
// Double-buffered segment frame store.
// CPU writes OR into an accumulator frame. A vblank rising edge copies the
// accumulator into the display frame one line per cycle, clearing each
// accumulator line as it goes. A frame with no in-range writes leaves the
// display untouched (hold), so software can skip frames without blanking.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | accepting writes, watching vblank for a rising edge
//   S_COPY | line_idx_q selects the line being moved accum -> display
module segment_frame_latch #(
  parameter int MAX_X_SEGMENT = 9,
  parameter int MAX_Y_SEGMENT = 16,
  parameter int MAX_Z_SEGMENT = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vblank,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [3:0]               wr_x,
  input  logic [1:0]               wr_z,
  input  logic [MAX_Y_SEGMENT-1:0] wr_data,
  output logic [MAX_X_SEGMENT-1:0][MAX_Y_SEGMENT-1:0][MAX_Z_SEGMENT-1:0] segments_out,
  output logic                     commit_done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_COPY = 1'b1
  } state_t;

  localparam logic [3:0]  LAST_LINE = 4'(MAX_X_SEGMENT - 1);
  localparam logic [31:0] X_LIMIT   = 32'(MAX_X_SEGMENT);
  localparam logic [31:0] Z_LIMIT   = 32'(MAX_Z_SEGMENT);

  typedef logic [MAX_X_SEGMENT-1:0][MAX_Y_SEGMENT-1:0][MAX_Z_SEGMENT-1:0] frame_t;

  state_t     state_q, state_d;
  logic [3:0] line_idx_q, line_idx_d;
  frame_t     accum_q, accum_d;
  frame_t     display_q, display_d;
  logic       frame_written_q, frame_written_d;
  logic       commit_hold_q, commit_hold_d;
  logic       vblank_dly_q;
  logic       commit_done_q, commit_done_d;

  logic        wr_fire;
  logic        wr_in_range;
  logic        wr_hit;
  logic        commit_start;
  logic        copy_active;
  logic        last_line;
  logic [31:0] wr_x_ext;
  logic [31:0] wr_z_ext;

  assign wr_x_ext     = {28'd0, wr_x};
  assign wr_z_ext     = {30'd0, wr_z};
  assign wr_in_range  = (wr_x_ext < X_LIMIT) && (wr_z_ext < Z_LIMIT);
  assign wr_fire      = wr_valid && wr_ready;
  assign wr_hit       = wr_fire && wr_in_range;
  assign commit_start = (state_q == S_IDLE) && vblank && !vblank_dly_q;
  assign copy_active  = (state_q == S_COPY);
  assign last_line    = (line_idx_q == LAST_LINE);

  assign segments_out = display_q;
  assign commit_done  = commit_done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start on a vblank rising edge, return after the last line.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (commit_start) state_d = S_COPY;
      S_COPY: if (last_line)    state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: writes only accepted while idle and out of reset.
  always_comb begin
    wr_ready      = reset_n && (state_q == S_IDLE);
    commit_done_d = copy_active && last_line;
  end

  // Line counter, sticky written flag and hold decision for the commit.
  always_comb begin
    line_idx_d      = line_idx_q;
    frame_written_d = frame_written_q;
    commit_hold_d   = commit_hold_q;

    if (commit_start) begin
      line_idx_d = 4'd0;
    end else if (copy_active) begin
      line_idx_d = last_line ? 4'd0 : line_idx_q + 4'd1;
    end

    if (wr_hit) begin
      frame_written_d = 1'b1;
    end
    if (copy_active && last_line) begin
      frame_written_d = 1'b0;
    end

    // A write landing in the commit-start cycle belongs to this frame.
    if (commit_start) begin
      commit_hold_d = !(frame_written_q || wr_hit);
    end
  end

  // Accumulator merge and per-line copy/clear.
  always_comb begin
    accum_d   = accum_q;
    display_d = display_q;
    for (int x = 0; x < MAX_X_SEGMENT; x++) begin
      if (wr_hit && (4'(x) == wr_x)) begin
        for (int y = 0; y < MAX_Y_SEGMENT; y++) begin
          for (int z = 0; z < MAX_Z_SEGMENT; z++) begin
            if (2'(z) == wr_z) begin
              accum_d[x][y][z] = accum_q[x][y][z] | wr_data[y];
            end
          end
        end
      end
      if (copy_active && (4'(x) == line_idx_q)) begin
        if (!commit_hold_q) begin
          display_d[x] = accum_q[x];
        end
        accum_d[x] = '0;
      end
    end
  end

  // Datapath and control registers; reset also aborts an in-flight commit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      line_idx_q      <= 4'd0;
      accum_q         <= '0;
      display_q       <= '0;
      frame_written_q <= 1'b0;
      commit_hold_q   <= 1'b0;
      vblank_dly_q    <= 1'b0;
      commit_done_q   <= 1'b0;
    end else begin
      line_idx_q      <= line_idx_d;
      accum_q         <= accum_d;
      display_q       <= display_d;
      frame_written_q <= frame_written_d;
      commit_hold_q   <= commit_hold_d;
      vblank_dly_q    <= vblank;
      commit_done_q   <= commit_done_d;
    end
  end

endmodule

// File: tb/tb_segment_frame_latch.sv
// Bench for segment_frame_latch: frame-level reference model, directed
// scenarios plus randomized frames.
module tb_segment_frame_latch;

  localparam int NX = 9;
  localparam int NY = 16;
  localparam int NZ = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          vblank;
  logic          wr_valid;
  logic          wr_ready;
  logic [3:0]    wr_x;
  logic [1:0]    wr_z;
  logic [NY-1:0] wr_data;
  logic [NX-1:0][NY-1:0][NZ-1:0] segments_out;
  logic          commit_done;

  int tests_run    = 0;
  int tests_failed = 0;

  bit m_acc  [NX][NY][NZ];
  bit m_disp [NX][NY][NZ];
  bit m_fw;

  segment_frame_latch #(
    .MAX_X_SEGMENT(NX),
    .MAX_Y_SEGMENT(NY),
    .MAX_Z_SEGMENT(NZ)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .vblank(vblank),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_x(wr_x),
    .wr_z(wr_z),
    .wr_data(wr_data),
    .segments_out(segments_out),
    .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear_all();
    for (int x = 0; x < NX; x++)
      for (int y = 0; y < NY; y++)
        for (int z = 0; z < NZ; z++) begin
          m_acc[x][y][z]  = 1'b0;
          m_disp[x][y][z] = 1'b0;
        end
    m_fw = 1'b0;
  endfunction

  function automatic void model_write(int x, int z, logic [NY-1:0] d);
    if (x < NX && z < NZ) begin
      for (int y = 0; y < NY; y++) m_acc[x][y][z] = m_acc[x][y][z] | d[y];
      m_fw = 1'b1;
    end
  endfunction

  function automatic void model_commit();
    for (int x = 0; x < NX; x++)
      for (int y = 0; y < NY; y++)
        for (int z = 0; z < NZ; z++) begin
          if (m_fw) m_disp[x][y][z] = m_acc[x][y][z];
          m_acc[x][y][z] = 1'b0;
        end
    m_fw = 1'b0;
  endfunction

  function automatic int diff_count();
    int c = 0;
    for (int x = 0; x < NX; x++)
      for (int y = 0; y < NY; y++)
        for (int z = 0; z < NZ; z++)
          if (segments_out[x][y][z] !== m_disp[x][y][z]) c++;
    return c;
  endfunction

  function automatic int line_diff(int x);
    int c = 0;
    for (int y = 0; y < NY; y++)
      for (int z = 0; z < NZ; z++)
        if (segments_out[x][y][z] !== m_disp[x][y][z]) c++;
    return c;
  endfunction

  task automatic do_write(input int x, input int z, input logic [NY-1:0] d);
    wr_valid = 1'b1;
    wr_x     = 4'(x);
    wr_z     = 2'(z);
    wr_data  = d;
    cyc();
    wr_valid = 1'b0;
    model_write(x, z, d);
  endtask

  // Raise vblank and count edges until commit_done (bounded at 20).
  task automatic do_commit(output int n);
    vblank = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (commit_done !== 1'b1 && n < 20);
    vblank = 1'b0;
    cyc();
    model_commit();
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    vblank   = 1'b0;
    wr_valid = 1'b1;
    wr_x     = 4'd1;
    wr_z     = 2'd1;
    wr_data  = '1;
    repeat (3) cyc();
    tests_run++;
    if (wr_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b expected 0", wr_ready);
    end
    tests_run++;
    if ($countones(segments_out) !== 0) begin
      tests_failed++;
      $display("FAIL reset_display: got %0d set bits expected 0", $countones(segments_out));
    end
    tests_run++;
    if (commit_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_done: got %b expected 0", commit_done);
    end
    wr_valid = 1'b0;
    reset_n  = 1'b1;
    cyc();
    model_clear_all();
    tests_run++;
    if (wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b expected 1", wr_ready);
    end
  endtask

  task automatic test_single_write();
    int n;
    do_write(2, 1, 16'h8001);
    tests_run++;
    if ($countones(segments_out) !== 0) begin
      tests_failed++;
      $display("FAIL single_early_visible: got %0d set bits expected 0", $countones(segments_out));
    end
    do_commit(n);
    tests_run++;
    if (n !== 10) begin
      tests_failed++;
      $display("FAIL single_latency: got %0d expected 10", n);
    end
    tests_run++;
    if (segments_out[2][0][1] !== 1'b1 || segments_out[2][15][1] !== 1'b1 ||
        $countones(segments_out) !== 2) begin
      tests_failed++;
      $display("FAIL single_bits: got [2][0][1]=%b [2][15][1]=%b count=%0d expected 1 1 2",
               segments_out[2][0][1], segments_out[2][15][1], $countones(segments_out));
    end
    tests_run++;
    if (commit_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done_width: got %b expected 0", commit_done);
    end
  endtask

  task automatic test_or_accum();
    int n;
    do_write(0, 0, 16'h0001);
    do_write(0, 0, 16'h0002);
    do_commit(n);
    tests_run++;
    if (segments_out[0][0][0] !== 1'b1 || segments_out[0][1][0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL or_bits: got %b %b expected 1 1", segments_out[0][0][0], segments_out[0][1][0]);
    end
    tests_run++;
    if (diff_count() !== 0) begin
      tests_failed++;
      $display("FAIL or_frame: got %0d differing bits expected 0", diff_count());
    end
  endtask

  task automatic test_hold();
    int n;
    int ones;
    do_write(5, 3, 16'hFFFF);
    do_commit(n);
    do_commit(n);
    ones = 0;
    for (int y = 0; y < NY; y++) if (segments_out[5][y][3] === 1'b1) ones++;
    tests_run++;
    if (ones !== NY) begin
      tests_failed++;
      $display("FAIL hold_line5: got %0d ones expected %0d", ones, NY);
    end
    tests_run++;
    if (diff_count() !== 0) begin
      tests_failed++;
      $display("FAIL hold_frame: got %0d differing bits expected 0", diff_count());
    end
    do_write(5, 3, 16'h0000);
    do_commit(n);
    tests_run++;
    if ($countones(segments_out) !== 0) begin
      tests_failed++;
      $display("FAIL hold_zero_frame: got %0d set bits expected 0", $countones(segments_out));
    end
  endtask

  task automatic test_ready_window();
    int n;
    int low;
    int dones;
    int bad_x [2] = '{9, 15};
    do_write(3, 2, 16'h00F0);
    do_commit(n);
    foreach (bad_x[i]) begin
      wr_valid = 1'b1;
      wr_x     = 4'(bad_x[i]);
      wr_z     = 2'd0;
      wr_data  = 16'hFFFF;
      vblank   = 1'b1;
      low      = 0;
      dones    = 0;
      for (int k = 0; k < 14; k++) begin
        cyc();
        if (wr_ready === 1'b0) low++;
        if (commit_done === 1'b1) dones++;
      end
      vblank   = 1'b0;
      wr_valid = 1'b0;
      cyc();
      model_commit();
      tests_run++;
      if (low !== 9) begin
        tests_failed++;
        $display("FAIL ready_low_x%0d: got %0d cycles expected 9", bad_x[i], low);
      end
      tests_run++;
      if (dones !== 1) begin
        tests_failed++;
        $display("FAIL ready_done_count_x%0d: got %0d expected 1", bad_x[i], dones);
      end
      tests_run++;
      if (diff_count() !== 0) begin
        tests_failed++;
        $display("FAIL ready_discard_x%0d: got %0d differing bits expected 0", bad_x[i], diff_count());
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [NY-1:0] d;
    d        = NY'($urandom) | 16'h0100;
    wr_valid = 1'b1;
    wr_x     = 4'd7;
    wr_z     = 2'd2;
    wr_data  = d;
    vblank   = 1'b1;
    #1;
    tests_run++;
    if (wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready_at_start: got %b expected 1", wr_ready);
    end
    model_write(7, 2, d);
    n = 0;
    do begin
      cyc();
      wr_valid = 1'b0;
      n++;
    end while (commit_done !== 1'b1 && n < 20);
    vblank = 1'b0;
    cyc();
    model_commit();
    tests_run++;
    if (n !== 10) begin
      tests_failed++;
      $display("FAIL b2b_latency: got %0d expected 10", n);
    end
    tests_run++;
    if (diff_count() !== 0) begin
      tests_failed++;
      $display("FAIL b2b_merge: got %0d differing bits expected 0", diff_count());
    end
    do_commit(n);
    do_write(8, 0, 16'h0F0F);
    do_commit(n);
    tests_run++;
    if (diff_count() !== 0 || n !== 10) begin
      tests_failed++;
      $display("FAIL b2b_second: got %0d diffs latency %0d expected 0 and 10", diff_count(), n);
    end
  endtask

  task automatic test_vblank_held();
    int first;
    int dones;
    reset_n = 1'b0;
    vblank  = 1'b1;
    repeat (2) cyc();
    model_clear_all();
    reset_n = 1'b1;
    first   = -1;
    dones   = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (commit_done === 1'b1) begin
        dones++;
        if (first < 0) first = k;
      end
    end
    vblank = 1'b0;
    cyc();
    tests_run++;
    if (first !== 10) begin
      tests_failed++;
      $display("FAIL held_first_done: got %0d expected 10", first);
    end
    tests_run++;
    if (dones !== 1) begin
      tests_failed++;
      $display("FAIL held_single_commit: got %0d expected 1", dones);
    end
  endtask

  task automatic test_reset_mid_copy();
    int n;
    int dones;
    do_write(4, 1, 16'h1234);
    do_write(6, 0, 16'h00FF);
    do_commit(n);
    do_write(6, 2, 16'hABCD);
    vblank = 1'b1;
    repeat (4) cyc();
    tests_run++;
    if (line_diff(4) !== 0 || line_diff(6) !== 0) begin
      tests_failed++;
      $display("FAIL midcopy_pending_lines: got %0d/%0d differing bits expected 0/0",
               line_diff(4), line_diff(6));
    end
    reset_n = 1'b0;
    cyc();
    tests_run++;
    if (wr_ready !== 1'b0 || $countones(segments_out) !== 0) begin
      tests_failed++;
      $display("FAIL midcopy_reset: got ready=%b bits=%0d expected 0 0",
               wr_ready, $countones(segments_out));
    end
    vblank = 1'b0;
    cyc();
    reset_n = 1'b1;
    model_clear_all();
    cyc();
    tests_run++;
    if (wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midcopy_release_ready: got %b expected 1", wr_ready);
    end
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      cyc();
      if (commit_done === 1'b1) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL midcopy_no_done: got %0d pulses expected 0", dones);
    end
    do_write(1, 1, 16'h0001);
    do_commit(n);
    tests_run++;
    if (diff_count() !== 0) begin
      tests_failed++;
      $display("FAIL midcopy_accum_cleared: got %0d differing bits expected 0", diff_count());
    end
  endtask

  task automatic test_random();
    int n;
    int nw;
    for (int f = 0; f < 12; f++) begin
      nw = $urandom_range(0, 5);
      for (int w = 0; w < nw; w++) begin
        do_write($urandom_range(0, 10), $urandom_range(0, 3), NY'($urandom));
        repeat ($urandom_range(0, 2)) cyc();
      end
      do_commit(n);
      tests_run++;
      if (n !== 10) begin
        tests_failed++;
        $display("FAIL rand_latency_f%0d: got %0d expected 10", f, n);
      end
      tests_run++;
      if (diff_count() !== 0) begin
        tests_failed++;
        $display("FAIL rand_frame_f%0d: got %0d differing bits expected 0", f, diff_count());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_or_accum();
    test_hold();
    test_ready_window();
    test_back_to_back();
    test_vblank_held();
    test_reset_mid_copy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/segment_frame_latch.md
SEGMENT_FRAME_LATCH -- requirements
Module: segment_frame_latch

Interface
REQ-001 SHALL have parameter MAX_X_SEGMENT, default 9, number of segment lines (x).
REQ-002 SHALL have parameter MAX_Y_SEGMENT, default 16, number of columns per line (y).
REQ-003 SHALL have parameter MAX_Z_SEGMENT, default 4, number of H rows (z).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port vblank  input  1  video vertical blank, clk-synchronous.
REQ-007 SHALL have port wr_valid  input  1  CPU segment write request.
REQ-008 SHALL have port wr_ready  output  1  write accepted when wr_valid&&wr_ready.
REQ-009 SHALL have port wr_x  input  4  target line.
REQ-010 SHALL have port wr_z  input  2  target row (H strobe index).
REQ-011 SHALL have port wr_data  input  MAX_Y_SEGMENT  one bit per column; bit y drives column y.
REQ-012 SHALL have port segments_out  output  array [MAX_X_SEGMENT][MAX_Y_SEGMENT] of MAX_Z_SEGMENT bits  displayed segment state, indexed [x][y][z].
REQ-013 SHALL have port commit_done  output  1  one-cycle pulse when a frame commit completes.

Function
REQ-014 SHALL hold two arrays, same shape as segments_out: accumulator (accum) and display (driving segments_out directly from flops).
REQ-015 SHALL hold sticky flag frame_written, set on any accepted in-range write, cleared by commit.
REQ-016 SHALL implement FSM states IDLE and COPY, with line counter line_idx (4 bits).
REQ-017 SHALL drive wr_ready = 1 exactly when state is IDLE and reset_n is high.
REQ-018 On accepted write with wr_x < MAX_X_SEGMENT and wr_z < MAX_Z_SEGMENT: accum[wr_x][y][wr_z] |= wr_data[y] for all y, next cycle; other bits unchanged.
REQ-019 Accepted write with out-of-range wr_x or wr_z SHALL be consumed and discarded; no state change, frame_written unchanged.
REQ-020 SHALL register vblank into vblank_d; commit start = (state IDLE) && vblank && !vblank_d.
REQ-021 Write accepted in the same cycle as commit start SHALL be merged into accum before copying and belong to the committing frame.
REQ-022 On commit start: next state COPY, line_idx = 0, snapshot frame_written into commit_hold (hold = !frame_written).
REQ-023 In COPY, each cycle for line L = line_idx: if commit_hold is 0, display[L] <= accum[L]; if 1, display[L] unchanged; accum[L] <= 0 in both cases.
REQ-024 In COPY, line_idx increments each cycle; after copying line MAX_X_SEGMENT-1, next state IDLE, frame_written cleared, commit_done = 1 for that next cycle only.
REQ-025 Commit duration SHALL be exactly MAX_X_SEGMENT cycles in COPY; commit_done asserts MAX_X_SEGMENT+1 cycles after the cycle detecting the vblank rising edge.
REQ-026 vblank edges during COPY SHALL be ignored (no queued commit); vblank held high SHALL trigger only one commit.
REQ-027 Write-to-display latency: accepted write visible on segments_out after the next completed commit, never earlier.
REQ-028 Lines not yet copied SHALL keep prior display values mid-commit (line-by-line update permitted; tearing confined to vblank).
REQ-029 Bits of wr_data beyond MAX_Y_SEGMENT do not exist; wr_x width fixed at 4, wr_z at 2 regardless of parameters.

Reset
REQ-030 While reset_n low at a clock edge: state IDLE, line_idx 0, accum all 0, display all 0, frame_written 0, commit_hold 0, vblank_d 0, commit_done 0, wr_ready 0.
REQ-031 Reset asserted during COPY SHALL abort the commit; after release all arrays read 0 and state is IDLE.
REQ-032 vblank high on the first cycle after reset release SHALL count as a rising edge (vblank_d reset 0).

Verification
REQ-033 Write x=2,z=1,data=0x8001, then vblank 0->1 -> commit_done after 10 cycles; segments_out[2][0][1]=1, [2][15][1]=1, all others 0.
REQ-034 Writes x=0,z=0,data=0x0001 and x=0,z=0,data=0x0002 in one frame, then commit -> segments_out[0][0][0]=1 and [0][1][0]=1 (OR accumulation).
REQ-035 Frame 1 commits x=5,z=3,data=0xFFFF; frame 2 has no writes, commit -> segments_out[5][*][3] still all 1 (hold); frame 3 writes x=5,z=3,data=0 only -> after commit, all 0.
REQ-036 Hold wr_valid high across vblank rising edge -> wr_ready low for exactly 9 cycles; write with wr_x=9 or wr_x=15 accepted, no segments_out change after commit.
REQ-037 Pull reset_n low on the 4th COPY cycle -> next cycle wr_ready=0, segments_out all 0; after release, state IDLE, wr_ready=1, no commit_done pulse.
